// File: rtl/vga_timing_receiver_pkg.sv
// Purpose : shared constants, FSM state encoding and a saturating-increment
//           helper for the VGA timing receiver.
// Contents: nominal 640x480 geometry (800 clocks/line, 525 lines/frame),
//           rx_state_e (IDLE / MEASURE / LOCKED), sat_inc10().
package vga_timing_receiver_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_e;

  // Coordinates and line counts stick at 1023 instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_timing_receiver_if.sv
// Purpose : bundles the video inputs (as driven to the DAC) and the
//           receiver's measurement outputs.
// Modports: master - video source / observer (drives i*, reads o*)
//           slave  - the receiver (reads i*, drives o*)
interface vga_timing_receiver_if;
  logic        iHS;
  logic        iVS;
  logic        iBLANK_n;
  logic [7:0]  iR;
  logic [7:0]  iG;
  logic [7:0]  iB;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic        oPIX_VALID;
  logic        oFRAME_START;
  logic        oLOCKED;
  logic [9:0]  oH_ACTIVE;
  logic [9:0]  oV_ACTIVE;
  logic [10:0] oH_TOTAL;
  logic [31:0] oFRAME_SUM;
  logic [7:0]  oERR_CNT;

  modport master (
    output iHS, iVS, iBLANK_n, iR, iG, iB,
    input  oX, oY, oPIX_VALID, oFRAME_START, oLOCKED,
           oH_ACTIVE, oV_ACTIVE, oH_TOTAL, oFRAME_SUM, oERR_CNT
  );

  modport slave (
    input  iHS, iVS, iBLANK_n, iR, iG, iB,
    output oX, oY, oPIX_VALID, oFRAME_START, oLOCKED,
           oH_ACTIVE, oV_ACTIVE, oH_TOTAL, oFRAME_SUM, oERR_CNT
  );
endinterface

// File: rtl/vga_timing_receiver_sync_edge.sv
// Purpose : two-stage register of HS, VS and BLANK_n with sync polarity
//           normalised to active-high, plus edge detection (s1 vs s2).
// Ports   : clk_i, rst_i (async, active-high); hs_i, vs_i, blank_n_i raw;
//           hs_rise_o / vs_rise_o = sync leading edges, blank_fall_o = end of
//           active line, blank_s1_o = registered BLANK_n (stage s1).
module vga_timing_receiver_sync_edge #(
  parameter bit SYNC_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hs_i,
  input  logic vs_i,
  input  logic blank_n_i,
  output logic hs_rise_o,
  output logic vs_rise_o,
  output logic blank_fall_o,
  output logic blank_s1_o
);

  // bit order: {hs, vs, blank_n}; sync bits are 1 while the pulse is active
  logic [2:0] s1_d, s1_q, s2_q;

  assign s1_d = {(SYNC_LOW ? ~hs_i : hs_i), (SYNC_LOW ? ~vs_i : vs_i), blank_n_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  assign hs_rise_o    = s1_q[2] & ~s2_q[2];
  assign vs_rise_o    = s1_q[1] & ~s2_q[1];
  assign blank_fall_o = ~s1_q[0] & s2_q[0];
  assign blank_s1_o   = s1_q[0];

endmodule

// File: rtl/vga_timing_receiver.sv
// Purpose : sink-side VGA timing checker. Recovers pixel coordinates,
//           measures line/frame geometry, locks against the expected
//           geometry and sums R+G+B over each frame's active pixels.
// Ports   : iVGA_CLK pixel clock, iRST async active-high reset,
//           vga (slave modport) carrying sync/blank/pixel inputs and all
//           measurement outputs.
//
//  state   | meaning
//  IDLE    | after reset; first (partial) frame is discarded
//  MEASURE | evaluating frames, counting consecutive matches
//  LOCKED  | LOCK_FRAMES matching frames seen in a row
module vga_timing_receiver
  import vga_timing_receiver_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_LOW    = 1'b1
) (
  input  logic                  iVGA_CLK,
  input  logic                  iRST,
  vga_timing_receiver_if.slave  vga
);

  localparam logic [9:0]  H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
  localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
  localparam logic [3:0]  LOCK_L  = 4'(LOCK_FRAMES);

  logic hs_rise, vs_rise, blank_fall, blank_s1;

  vga_timing_receiver_sync_edge #(.SYNC_LOW(SYNC_LOW)) u_sync (
    .clk_i        (iVGA_CLK),
    .rst_i        (iRST),
    .hs_i         (vga.iHS),
    .vs_i         (vga.iVS),
    .blank_n_i    (vga.iBLANK_n),
    .hs_rise_o    (hs_rise),
    .vs_rise_o    (vs_rise),
    .blank_fall_o (blank_fall),
    .blank_s1_o   (blank_s1)
  );

  logic [7:0]  r_q, g_q, b_q;
  logic [9:0]  x_q, y_q, line_cnt_q, h_active_q, v_active_q;
  logic [10:0] h_cnt_q, h_total_q;
  logic [31:0] acc_q, sum_q;
  logic        frame_start_q, line_err_q;
  logic [9:0]  pix_sum;

  rx_state_e   state_q, state_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        frame_match;

  assign pix_sum = 10'(r_q) + 10'(g_q) + 10'(b_q);

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_cnt_q    <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      h_cnt_q       <= '0;
      h_total_q     <= '0;
      acc_q         <= '0;
      sum_q         <= '0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      r_q           <= vga.iR;
      g_q           <= vga.iG;
      b_q           <= vga.iB;
      frame_start_q <= vs_rise;

      // x tracks the pixel entering s1 this edge; blank_s1 is the previous one
      x_q <= (vga.iBLANK_n && blank_s1) ? sat_inc10(x_q) : '0;

      if (hs_rise) begin
        h_total_q <= h_cnt_q;
        h_cnt_q   <= 11'd1;
      end else if (h_cnt_q != 11'h7FF) begin
        h_cnt_q <= h_cnt_q + 11'd1;
      end

      if (blank_fall) begin
        h_active_q <= line_cnt_q;
        line_cnt_q <= '0;
        y_q        <= sat_inc10(y_q);
        if (y_q != '0 && line_cnt_q != h_active_q) line_err_q <= 1'b1;
      end else if (blank_s1) begin
        line_cnt_q <= sat_inc10(line_cnt_q);
      end

      // Frame end takes priority over the line bookkeeping above.
      if (vs_rise) begin
        sum_q      <= acc_q;
        acc_q      <= blank_s1 ? 32'(pix_sum) : '0;
        v_active_q <= y_q;
        y_q        <= '0;
        line_err_q <= 1'b0;
      end else if (blank_s1) begin
        acc_q <= acc_q + 32'(pix_sum);
      end
    end
  end

  // Uses registered (pre-edge) measurements, so a coincident HS edge
  // cannot disturb the evaluation of the frame that just ended.
  assign frame_match = (h_active_q == H_ACT_L) && (y_q == V_ACT_L) &&
                       (h_total_q == H_TOT_L) && !line_err_q;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (vs_rise) begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_MEASURE;
          match_cnt_d = '0;
        end
        ST_MEASURE: begin
          if (frame_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 >= LOCK_L) state_d = ST_LOCKED;
          end else begin
            match_cnt_d = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (!frame_match) begin
            state_d     = ST_MEASURE;
            match_cnt_d = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign vga.oX           = x_q;
  assign vga.oY           = y_q;
  assign vga.oPIX_VALID   = blank_s1;
  assign vga.oFRAME_START = frame_start_q;
  assign vga.oLOCKED      = (state_q == ST_LOCKED);
  assign vga.oH_ACTIVE    = h_active_q;
  assign vga.oV_ACTIVE    = v_active_q;
  assign vga.oH_TOTAL     = h_total_q;
  assign vga.oFRAME_SUM   = sum_q;
  assign vga.oERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Testbench for vga_timing_receiver using a reduced geometry
// (16x12 active, 24 clocks/line, 16 lines/frame) so full frames stay short.
module tb_vga_timing_receiver;
  import vga_timing_receiver_pkg::*;

  localparam int HA = 16, HFP = 2, HSW = 4, HT = 24;
  localparam int VA = 12, VFP = 1, VSW = 2, VT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_receiver_if vif();

  vga_timing_receiver #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .LOCK_FRAMES(2), .SYNC_LOW(1'b1)
  ) dut (
    .iVGA_CLK (clk),
    .iRST     (rst),
    .vga      (vif)
  );

  typedef struct {
    logic       v;
    logic [9:0] x;
  } pix_exp_t;

  typedef struct {
    logic        locked;
    logic [7:0]  err;
    logic [9:0]  v_act;
    logic [9:0]  h_act;
    logic [10:0] h_tot;
    logic [31:0] sum;
  } frm_exp_t;

  pix_exp_t pix_q[$];
  frm_exp_t frm_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic       m_v;
  logic [9:0] m_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock of stimulus; the expected coordinate/valid is queued
  // for the edge that registers it.
  task automatic drive(input logic hs_act, input logic vs_act, input logic blank,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_exp_t e;
    @(negedge clk);
    vif.iHS      = ~hs_act;
    vif.iVS      = ~vs_act;
    vif.iBLANK_n = blank;
    vif.iR       = blank ? r : 8'hA5;
    vif.iG       = blank ? g : 8'h5A;
    vif.iB       = blank ? b : 8'hC3;
    if (rst) begin
      m_v = 1'b0;
      m_x = '0;
    end else if (blank) begin
      m_x = m_v ? ((m_x == 10'h3FF) ? m_x : m_x + 10'd1) : 10'd0;
      m_v = 1'b1;
    end else begin
      m_x = '0;
      m_v = 1'b0;
    end
    e.v = m_v;
    e.x = m_x;
    pix_q.push_back(e);
  endtask

  task automatic set_rst(input logic v);
    @(negedge clk);
    rst = v;
    if (v) begin
      m_v = 1'b0;
      m_x = '0;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_oX"},           vif.oX, 0);
    chk({p, "_oY"},           vif.oY, 0);
    chk({p, "_oPIX_VALID"},   vif.oPIX_VALID, 0);
    chk({p, "_oFRAME_START"}, vif.oFRAME_START, 0);
    chk({p, "_oLOCKED"},      vif.oLOCKED, 0);
    chk({p, "_oH_ACTIVE"},    vif.oH_ACTIVE, 0);
    chk({p, "_oV_ACTIVE"},    vif.oV_ACTIVE, 0);
    chk({p, "_oH_TOTAL"},     vif.oH_TOTAL, 0);
    chk({p, "_oFRAME_SUM"},   vif.oFRAME_SUM, 0);
    chk({p, "_oERR_CNT"},     vif.oERR_CNT, 0);
  endtask

  // Full frame: active lines first, VS leading edge at (line VA+VFP, vs_hc).
  task automatic frame(input int short_line, input int vs_hc,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic exp_locked, input logic [7:0] exp_err);
    int cnt, pos, vs_start, vs_end, n_act;
    logic act, hs, vs;
    frm_exp_t e;
    cnt      = 0;
    vs_start = (VA + VFP) * HT + vs_hc;
    vs_end   = vs_start + VSW * HT;
    for (int vc = 0; vc < VT; vc++) begin
      for (int hc = 0; hc < HT; hc++) begin
        pos   = vc * HT + hc;
        n_act = (vc == short_line) ? HA - 1 : HA;
        act   = (vc < VA) && (hc < n_act);
        hs    = (hc >= HA + HFP) && (hc < HA + HFP + HSW);
        vs    = (pos >= vs_start) && (pos < vs_end);
        if (pos == vs_start) begin
          e.locked = exp_locked;
          e.err    = exp_err;
          e.v_act  = 10'(VA);
          e.h_act  = 10'(HA);
          e.h_tot  = 11'(HT);
          e.sum    = 32'(cnt) * (32'(r) + 32'(g) + 32'(b));
          frm_q.push_back(e);
        end
        if (act) cnt++;
        drive(hs, vs, act, r, g, b);
      end
    end
  endtask

  // BLANK_n stuck high for 1100 clocks, HS keeps running, then VS.
  task automatic long_blank_frame(input logic exp_locked, input logic [7:0] exp_err);
    int hc;
    frm_exp_t e;
    for (int i = 0; i < 1176; i++) begin
      hc = i % HT;
      if (i == 1104) begin
        e.locked = exp_locked;
        e.err    = exp_err;
        e.v_act  = 10'd1;
        e.h_act  = 10'd1023;
        e.h_tot  = 11'(HT);
        e.sum    = 32'd6600;
        frm_q.push_back(e);
      end
      drive((hc >= HA + HFP) && (hc < HA + HFP + HSW), (i >= 1104) && (i < 1152),
            i < 1100, 8'd1, 8'd2, 8'd3);
    end
  endtask

  initial begin
    pix_exp_t pe;
    frm_exp_t fe;
    forever begin
      @(posedge clk);
      #1;
      if (pix_q.size() > 0) begin
        pe = pix_q.pop_front();
        chk("pix_valid", vif.oPIX_VALID, pe.v);
        chk("pix_x", vif.oX, pe.x);
      end
      if (vif.oFRAME_START) begin
        chk("frame_expected", frm_q.size() != 0, 1);
        if (frm_q.size() != 0) begin
          fe = frm_q.pop_front();
          chk("frm_locked", vif.oLOCKED, fe.locked);
          chk("frm_err_cnt", vif.oERR_CNT, fe.err);
          chk("frm_v_active", vif.oV_ACTIVE, fe.v_act);
          chk("frm_h_active", vif.oH_ACTIVE, fe.h_act);
          chk("frm_h_total", vif.oH_TOTAL, fe.h_tot);
          chk("frm_sum", vif.oFRAME_SUM, fe.sum);
          chk("frm_y_cleared", vif.oY, 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_v = 1'b0;
    m_x = '0;
    vif.iHS = 1'b1; vif.iVS = 1'b1; vif.iBLANK_n = 1'b0;
    vif.iR = '0; vif.iG = '0; vif.iB = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    set_rst(1'b0);

    // lock acquisition: first frame discarded, then two matches
    frame(-1, 0, 8'd1,   8'd2,   8'd3,   1'b0, 8'd0);
    frame(-1, 0, 8'd10,  8'd20,  8'd30,  1'b0, 8'd0);
    frame(-1, 0, 8'd1,   8'd2,   8'd3,   1'b1, 8'd0);
    frame(-1, 0, 8'd255, 8'd255, 8'd255, 1'b1, 8'd0);
    // one short line while locked, then relock
    frame(5,  0, 8'd4,   8'd5,   8'd6,   1'b0, 8'd1);
    frame(-1, 0, 8'd1,   8'd1,   8'd1,   1'b0, 8'd1);
    frame(-1, 0, 8'd1,   8'd1,   8'd1,   1'b1, 8'd1);
    // VS and HS leading edges in the same clock
    frame(-1, HA + HFP, 8'd7, 8'd8,  8'd9, 1'b1, 8'd1);

    // reset in the middle of a frame while locked
    for (int i = 0; i < 5 * HT; i++)
      drive((i % HT >= HA + HFP) && (i % HT < HA + HFP + HSW), 1'b0, (i % HT) < HA,
            8'd9, 8'd9, 8'd9);
    repeat (2) @(negedge clk);
    chk("pre_reset_locked", vif.oLOCKED, 1);
    set_rst(1'b1);
    #1;
    chk_zero("mid_reset");
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    set_rst(1'b0);

    frame(-1, 0, 8'd2, 8'd3, 8'd4, 1'b0, 8'd0);
    frame(-1, 0, 8'd2, 8'd3, 8'd4, 1'b0, 8'd0);
    frame(-1, 0, 8'd2, 8'd3, 8'd4, 1'b1, 8'd0);
    // overlong active line: coordinate saturates, frame mismatches
    long_blank_frame(1'b0, 8'd1);
    frame(-1, 0, 8'd3, 8'd3, 8'd3, 1'b0, 8'd1);
    frame(-1, 0, 8'd3, 8'd3, 8'd3, 1'b1, 8'd1);

    repeat (4) @(negedge clk);
    chk("pix_q_drained", pix_q.size(), 0);
    chk("frm_q_drained", frm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
